// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants, piece-code encoding and colour palette.
// Used by the board redraw sequencer, the game logic and the preview renderer.
package tetris_pkg;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 20;
    localparam int unsigned CELL = 24;

    typedef enum logic [2:0] {
        PIECE_NONE = 3'd0,
        PIECE_I    = 3'd1,
        PIECE_O    = 3'd2,
        PIECE_T    = 3'd3,
        PIECE_S    = 3'd4,
        PIECE_Z    = 3'd5,
        PIECE_J    = 3'd6,
        PIECE_L    = 3'd7
    } piece_t;

    // RRR_GGG_BBB, indexed by piece code
    localparam logic [8:0] PALETTE [8] = '{
        9'h000, 9'h03F, 9'h1F8, 9'h147, 9'h038, 9'h1C0, 9'h007, 9'h1E0
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_START,
        S_WAIT,
        S_DONE
    } redraw_state_t;

    function automatic logic [8:0] piece_color(input logic [2:0] code);
        return PALETTE[code];
    endfunction

endpackage

// File: rtl/board_cell_palette.sv
// Combinational piece-code to 9-bit colour lookup.
module board_cell_palette
    import tetris_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [8:0] color_o
);

    always_comb begin
        color_o = piece_color(code_i);
    end

endmodule

// File: rtl/board_redraw_seq.sv
// Scans the playfield RAM in row-major order and launches one box draw per
// cell at its screen position, waiting for the renderer between cells.
module board_redraw_seq #(
    parameter int unsigned COLS     = tetris_pkg::COLS,
    parameter int unsigned ROWS     = tetris_pkg::ROWS,
    parameter int unsigned CELL     = tetris_pkg::CELL,
    parameter int unsigned ORIGIN_X = 200,
    parameter int unsigned ORIGIN_Y = 0,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              redraw,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [2:0]        cell_data,
    output logic              box_start,
    output logic [9:0]        box_x0,
    output logic [8:0]        box_y0,
    output logic [8:0]        box_color,
    input  logic              box_done,
    output logic              busy,
    output logic              frame_done
);
    import tetris_pkg::*;

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [9:0] X_ORG  = 10'(ORIGIN_X);
    localparam logic [8:0] Y_ORG  = 9'(ORIGIN_Y);
    localparam logic [9:0] X_STEP = 10'(CELL);
    localparam logic [8:0] Y_STEP = 9'(CELL);

    redraw_state_t     state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [9:0]        bx_q, bx_d;
    logic [8:0]        by_q, by_d;
    logic [8:0]        bc_q, bc_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              fdone_q, fdone_d;

    logic [8:0]        pal_color;
    logic              last_col, last_row;

    board_cell_palette u_palette (
        .code_i  (cell_data),
        .color_o (pal_color)
    );

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bc_d    = bc_q;

        if (redraw && state_q != S_IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (redraw) begin
                    state_d = S_RD;
                    row_d   = '0;
                    col_d   = '0;
                    x_d     = X_ORG;
                    y_d     = Y_ORG;
                    addr_d  = '0;
                end
            end
            S_RD: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                bx_d    = x_q;
                by_d    = y_q;
                bc_d    = pal_color;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (box_done) begin
                    if (last_row && last_col) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (last_col) begin
                            col_d = '0;
                            x_d   = X_ORG;
                            row_d = row_q + ROW_W'(1);
                            y_d   = y_q + Y_STEP;
                        end else begin
                            col_d = col_q + COL_W'(1);
                            x_d   = x_q + X_STEP;
                        end
                    end
                end
            end
            S_DONE: begin
                // A request arriving this very cycle is folded into the restart
                pend_d = 1'b0;
                if (pend_q || redraw) begin
                    state_d = S_RD;
                    row_d   = '0;
                    col_d   = '0;
                    x_d     = X_ORG;
                    y_d     = Y_ORG;
                    addr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        fdone_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            bc_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bc_q    <= bc_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
        end
    end

    assign cell_addr  = addr_q;
    assign box_start  = start_q;
    assign box_x0     = bx_q;
    assign box_y0     = by_q;
    assign box_color  = bc_q;
    assign busy       = busy_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_board_redraw_seq.sv
// Self-checking bench for board_redraw_seq: board RAM and renderer models,
// a launch monitor, and a cell-by-cell reference of the expected frame.
module tb_board_redraw_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       redraw;
    logic [7:0] cell_addr;
    logic [2:0] cell_data;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    board_redraw_seq #(
        .COLS     (10),
        .ROWS     (20),
        .CELL     (24),
        .ORIGIN_X (200),
        .ORIGIN_Y (0),
        .ADDR_W   (8)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .redraw     (redraw),
        .cell_addr  (cell_addr),
        .cell_data  (cell_data),
        .box_start  (box_start),
        .box_x0     (box_x0),
        .box_y0     (box_y0),
        .box_color  (box_color),
        .box_done   (box_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // synchronous board RAM
    int mem [256];
    always @(posedge clk) cell_data <= 3'(mem[cell_addr]);

    // renderer: box_done high for one cycle, lat cycles after box_start
    int lat    = 5;
    bit spur_en = 1'b0;
    initial begin
        box_done = 1'b0;
        forever begin
            @(negedge clk);
            if (box_start === 1'b1) begin
                automatic int  n = lat;
                automatic bit  ab = 1'b0;
                for (int i = 0; i < n; i++) begin
                    @(posedge clk);
                    if (reset === 1'b1) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    #1 box_done = 1'b1;
                    @(posedge clk);
                    if (spur_en) @(posedge clk);
                    #1 box_done = 1'b0;
                end
            end
        end
    end

    typedef struct {
        int     addr;
        int     x;
        int     y;
        int     color;
        longint cyc;
    } launch_t;

    launch_t launches[$];
    int      fd_cnt = 0;
    int      viol   = 0;
    longint  cyc    = 0;
    bit      outst  = 1'b0;
    bit      prev_start = 1'b0;
    int      hx, hy, hc;

    always @(posedge clk) cyc++;

    // monitor: record launches, count protocol violations
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            outst      = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (box_start === 1'b1) begin
                launch_t l;
                if (prev_start || outst) viol++;
                l.addr  = int'(cell_addr);
                l.x     = int'(box_x0);
                l.y     = int'(box_y0);
                l.color = int'(box_color);
                l.cyc   = cyc;
                launches.push_back(l);
                outst = 1'b1;
                hx = l.x; hy = l.y; hc = l.color;
            end else if (outst) begin
                if (int'(box_x0) != hx || int'(box_y0) != hy || int'(box_color) != hc) viol++;
                if (box_done === 1'b1) outst = 1'b0;
            end
            if (frame_done === 1'b1) fd_cnt++;
            prev_start = (box_start === 1'b1);
        end
    end

    function automatic int ref_color(int code);
        case (code)
            0: return 'h000;
            1: return 'h03F;
            2: return 'h1F8;
            3: return 'h147;
            4: return 'h038;
            5: return 'h1C0;
            6: return 'h007;
            7: return 'h1E0;
            default: return -1;
        endcase
    endfunction

    string bad_msg;

    // number of launches in [base, base+n) that differ from the reference for cells 0..n-1
    function automatic int frame_errors(int base, int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            int ex, ey, ec;
            ex = 200 + 24 * (k % 10);
            ey = 24 * (k / 10);
            ec = ref_color(mem[k]);
            if (base + k >= launches.size()) begin
                if (bad == 0) bad_msg = $sformatf("launch %0d missing", base + k);
                bad++;
            end else if (launches[base+k].addr != k || launches[base+k].x != ex ||
                         launches[base+k].y != ey || launches[base+k].color != ec) begin
                if (bad == 0)
                    bad_msg = $sformatf("launch %0d addr=%0d x=%0d y=%0d c=%03h, want addr=%0d x=%0d y=%0d c=%03h",
                                        base + k, launches[base+k].addr, launches[base+k].x,
                                        launches[base+k].y, launches[base+k].color, k, ex, ey, ec);
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic wait_frames(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (fd_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_launches(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (launches.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_redraw();
        @(posedge clk);
        #1 redraw = 1'b1;
        @(posedge clk);
        #1 redraw = 1'b0;
    endtask

    task automatic clear_stats();
        launches.delete();
        fd_cnt = 0;
        viol   = 0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        redraw = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({cell_addr, box_x0, box_y0, box_color, box_start, busy, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h x=%h y=%h c=%h st=%b busy=%b fd=%b, want all 0",
                     cell_addr, box_x0, box_y0, box_color, box_start, busy, frame_done);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        redraw = 1'b0;
        clear_stats();
        repeat (10) @(negedge clk);
        n_checks++;
        if (launches.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got starts=%0d busy=%b, want starts=0 busy=0", launches.size(), busy);
        end
    endtask

    task automatic test_empty_frame();
        bit ok;
        int nz, badgap;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        lat = 5;
        clear_stats();
        pulse_redraw();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || cell_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL redraw_busy: got busy=%b addr=%0d, want busy=1 addr=0", busy, cell_addr);
        end
        @(negedge clk);
        ok = (box_start === 1'b0);
        @(negedge clk);
        n_checks++;
        if (!(ok && box_start === 1'b1)) begin
            n_fail++;
            $display("FAIL first_start_latency: got start=%b on 3rd cycle (early=%b), want start on 3rd cycle only",
                     box_start, !ok);
        end
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done_seen: got seen=%b busy=%b, want seen=1 busy=1", ok, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got fd=%b busy=%b, want fd=0 busy=0", frame_done, busy);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (launches.size() != 200) begin
            n_fail++;
            $display("FAIL empty_count: got %0d starts, want 200", launches.size());
        end
        nz = 0;
        foreach (launches[i]) if (launches[i].color != 0) nz++;
        n_checks++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL empty_colors: got %0d nonzero colours, want 0", nz);
        end
        n_checks++;
        if (launches.size() < 200 || launches[0].x != 200 || launches[0].y != 0 ||
            launches[199].x != 416 || launches[199].y != 456) begin
            n_fail++;
            $display("FAIL empty_corners: got %0d starts (first/last), want first 200,0 last 416,456",
                     launches.size());
        end
        n_checks++;
        if (frame_errors(0, 200) != 0) begin
            n_fail++;
            $display("FAIL empty_sequence: got %s", bad_msg);
        end
        badgap = 0;
        for (int i = 1; i < launches.size(); i++)
            if (launches[i].cyc - launches[i-1].cyc != 8) badgap++;
        n_checks++;
        if (badgap != 0) begin
            n_fail++;
            $display("FAIL empty_gap: got %0d start gaps not equal to 8, want 0", badgap);
        end
        n_checks++;
        if (fd_cnt != 1 || viol != 0) begin
            n_fail++;
            $display("FAIL empty_protocol: got frame_done=%0d violations=%0d, want 1 and 0", fd_cnt, viol);
        end
    endtask

    task automatic test_single_cell();
        bit ok;
        int nz;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        mem[13] = 5;
        lat = 5;
        clear_stats();
        pulse_redraw();
        wait_frames(1, 3000, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || launches.size() != 200) begin
            n_fail++;
            $display("FAIL single_frame: got done=%b starts=%0d, want done=1 starts=200", ok, launches.size());
        end
        n_checks++;
        if (launches.size() < 14 || launches[13].x != 272 || launches[13].y != 24 || launches[13].color != 'h1C0) begin
            n_fail++;
            $display("FAIL single_cell14: got %0d starts or wrong cell 14 fields, want x=272 y=24 c=1C0",
                     launches.size());
        end
        nz = 0;
        foreach (launches[i]) if (launches[i].color != 0) nz++;
        n_checks++;
        if (nz != 1) begin
            n_fail++;
            $display("FAIL single_others: got %0d nonzero colours, want 1", nz);
        end
    endtask

    task automatic test_random_board();
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 7));
        lat = int'($urandom_range(1, 6));
        clear_stats();
        pulse_redraw();
        wait_frames(1, 4000, ok);
        repeat (12) @(negedge clk);
        n_checks++;
        if (!ok || launches.size() != 200) begin
            n_fail++;
            $display("FAIL random_frame: got done=%b starts=%0d, want done=1 starts=200", ok, launches.size());
        end
        n_checks++;
        if (frame_errors(0, 200) != 0) begin
            n_fail++;
            $display("FAIL random_sequence: got %s (lat=%0d)", bad_msg, lat);
        end
        n_checks++;
        if (fd_cnt != 1 || viol != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_protocol: got fd=%0d viol=%0d busy=%b, want 1 0 0", fd_cnt, viol, busy);
        end
    endtask

    task automatic test_redraw_while_busy();
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 7));
        lat = 3;
        clear_stats();
        pulse_redraw();
        wait_launches(30, 2000, ok);
        pulse_redraw();
        wait_launches(70, 2000, ok);
        pulse_redraw();
        wait_launches(120, 2000, ok);
        pulse_redraw();
        wait_frames(2, 6000, ok);
        repeat (30) @(negedge clk);
        n_checks++;
        if (!ok || launches.size() != 400 || fd_cnt != 2) begin
            n_fail++;
            $display("FAIL collapse_count: got starts=%0d frame_done=%0d, want 400 and 2", launches.size(), fd_cnt);
        end
        n_checks++;
        if (launches.size() < 201 || launches[200].addr != 0 || launches[200].x != 200 || launches[200].y != 0) begin
            n_fail++;
            $display("FAIL second_frame_start: got %0d starts or wrong 201st launch, want addr=0 x=200 y=0",
                     launches.size());
        end
        n_checks++;
        if (frame_errors(0, 200) != 0 || frame_errors(200, 200) != 0) begin
            n_fail++;
            $display("FAIL collapse_sequence: got %s", bad_msg);
        end
        n_checks++;
        if (viol != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collapse_protocol: got viol=%0d busy=%b, want 0 and 0", viol, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 7));
        lat = 5;
        clear_stats();
        pulse_redraw();
        wait_launches(50, 2000, ok);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if (!ok || {cell_addr, box_x0, box_y0, box_color, box_start, busy, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got reached=%b addr=%0d x=%0d y=%0d busy=%b, want all 0",
                     ok, cell_addr, box_x0, box_y0, busy);
        end
        clear_stats();
        repeat (40) @(negedge clk);
        n_checks++;
        if (launches.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got starts=%0d busy=%b, want 0 and 0", launches.size(), busy);
        end
        pulse_redraw();
        wait_frames(1, 3000, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!ok || launches.size() != 200 || frame_errors(0, 200) != 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got done=%b starts=%0d %s, want full frame from cell 0",
                     ok, launches.size(), bad_msg);
        end
    endtask

    task automatic test_slow_renderer();
        bit ok;
        int badgap;
        for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(1, 7));
        lat     = 1000;
        spur_en = 1'b1;
        clear_stats();
        pulse_redraw();
        wait_launches(3, 5000, ok);
        repeat (500) @(negedge clk);
        n_checks++;
        if (!ok || launches.size() != 3 || cell_addr !== 8'd2) begin
            n_fail++;
            $display("FAIL slow_hold: got starts=%0d addr=%0d, want 3 starts at addr 2", launches.size(), cell_addr);
        end
        n_checks++;
        if (frame_errors(0, 3) != 0) begin
            n_fail++;
            $display("FAIL slow_sequence: got %s", bad_msg);
        end
        badgap = 0;
        for (int i = 1; i < launches.size(); i++)
            if (launches[i].cyc - launches[i-1].cyc != 1003) badgap++;
        n_checks++;
        if (badgap != 0 || viol != 0) begin
            n_fail++;
            $display("FAIL slow_timing: got bad gaps=%0d violations=%0d, want 0 and 0", badgap, viol);
        end
        spur_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_empty_frame();
        test_single_cell();
        test_random_board();
        test_redraw_while_busy();
        test_reset_mid_frame();
        test_slow_renderer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
